// File: rtl/imm_encoder.sv
// imm_encoder: packs a 32-bit immediate into RISC-V instruction bit positions.
// It also expands a load-immediate request into a LUI/ADDI pair.
// Encoded words leave through a registered valid/ready stream, one request at a time.
module imm_encoder #(
    parameter logic [6:0] LUI_OP  = 7'b0110111,
    parameter logic [6:0] ADDI_OP = 7'b0010011
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_li,
    input  logic [2:0]  in_immsrc,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last,
    output logic        out_err
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned HI_W   = 20;
    localparam int unsigned LO_W   = 12;
    localparam int unsigned REG_W  = 5;

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_B = 3'b001;
    localparam logic [2:0] SRC_S = 3'b010;
    localparam logic [2:0] SRC_J = 3'b011;
    localparam logic [2:0] SRC_U = 3'b100;

    localparam logic [2:0] ADDI_F3 = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        EMIT1 = 2'b01,
        EMIT2 = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_instr_q, out_instr_d;
    logic              out_last_q, out_last_d;
    logic              out_err_q, out_err_d;
    logic [XLEN-1:0]   second_q, second_d;

    logic [XLEN-1:0]   enc_word;
    logic              enc_err;
    logic [HI_W-1:0]   li_hi;
    logic [LO_W-1:0]   li_lo;
    logic [REG_W-1:0]  li_rd;
    logic [XLEN-1:0]   lui_word;
    logic [XLEN-1:0]   addi_x0_word;
    logic [XLEN-1:0]   addi_rd_word;

    // Single-format packing: immediate fields overwrite the template, plus representability check
    always_comb begin
        enc_word = in_base;
        enc_err  = 1'b0;
        case (in_immsrc)
            SRC_I: begin
                enc_word[31:20] = in_imm[11:0];
                enc_err         = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            SRC_B: begin
                enc_word[31]    = in_imm[12];
                enc_word[30:25] = in_imm[10:5];
                enc_word[11:8]  = in_imm[4:1];
                enc_word[7]     = in_imm[11];
                enc_err         = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) | in_imm[0];
            end
            SRC_S: begin
                enc_word[31:25] = in_imm[11:5];
                enc_word[11:7]  = in_imm[4:0];
                enc_err         = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            SRC_J: begin
                enc_word[31]    = in_imm[20];
                enc_word[30:21] = in_imm[10:1];
                enc_word[20]    = in_imm[11];
                enc_word[19:12] = in_imm[19:12];
                enc_err         = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) | in_imm[0];
            end
            SRC_U: begin
                enc_word[31:12] = in_imm[31:12];
                enc_err         = |in_imm[11:0];
            end
            default: begin
                enc_word = in_base;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Load-immediate split: rounding hi up when lo is negative, so ADDI's sign extension cancels out
    always_comb begin
        li_hi        = in_imm[31:12] + HI_W'(in_imm[11]);
        li_lo        = in_imm[11:0];
        li_rd        = in_base[11:7];
        lui_word     = {li_hi, li_rd, LUI_OP};
        addi_x0_word = {li_lo, 5'd0, ADDI_F3, li_rd, ADDI_OP};
        addi_rd_word = {li_lo, li_rd, ADDI_F3, li_rd, ADDI_OP};
    end

    // Next-state and output-register logic for the accept / emit / second-word sequence
    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_last_d  = out_last_q;
        out_err_d   = out_err_q;
        second_d    = second_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d     = EMIT1;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    if (in_li) begin
                        out_err_d = 1'b0;
                        if (li_hi == '0) begin
                            out_instr_d = addi_x0_word;
                            out_last_d  = 1'b1;
                        end else if (li_lo == '0) begin
                            out_instr_d = lui_word;
                            out_last_d  = 1'b1;
                        end else begin
                            out_instr_d = lui_word;
                            out_last_d  = 1'b0;
                            second_d    = addi_rd_word;
                        end
                    end else begin
                        out_instr_d = enc_word;
                        out_last_d  = 1'b1;
                        out_err_d   = enc_err;
                    end
                end
            end
            EMIT1: begin
                if (out_valid_q && out_ready) begin
                    if (!out_last_q) begin
                        state_d     = EMIT2;
                        out_instr_d = second_q;
                        out_last_d  = 1'b1;
                        out_err_d   = 1'b0;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (out_valid_q && out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset drops any pending second word
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
            second_q    <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
            second_q    <= second_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_last  = out_last_q;
    assign out_err   = out_err_q;

endmodule
